// File: rtl/ex_operand_if.sv
// ID/EX operand-stage bus: decoded ID fields, later-stage forwarding sources,
// and the ALU-facing operand outputs.
interface ex_operand_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) ();
  logic            id_valid_i;
  logic [XLEN-1:0] id_pc_i;
  logic [XLEN-1:0] id_rd1_i;
  logic [XLEN-1:0] id_rd2_i;
  logic [XLEN-1:0] id_imm_i;
  logic [4:0]      id_rs1_i;
  logic [4:0]      id_rs2_i;
  logic [4:0]      id_rd_i;
  logic            id_use_rs1_i;
  logic            id_use_rs2_i;
  logic [OPW-1:0]  id_aluop_i;
  logic            id_alusrc_i;
  logic [7:0]      id_ctrl_i;
  logic            flush_i;
  logic            exmem_regwrite_i;
  logic            memwb_regwrite_i;
  logic [4:0]      exmem_rd_i;
  logic [4:0]      memwb_rd_i;
  logic [XLEN-1:0] exmem_data_i;
  logic [XLEN-1:0] memwb_data_i;

  logic [XLEN-1:0] alu_a_o;
  logic [XLEN-1:0] alu_b_o;
  logic [OPW-1:0]  alu_op_o;
  logic [XLEN-1:0] alu_pc_o;
  logic [XLEN-1:0] store_data_o;
  logic [4:0]      ex_rd_o;
  logic [7:0]      ex_ctrl_o;
  logic            ex_valid_o;
  logic            load_use_stall_o;

  modport master (
    output id_valid_i, id_pc_i, id_rd1_i, id_rd2_i, id_imm_i,
    output id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i, id_use_rs2_i,
    output id_aluop_i, id_alusrc_i, id_ctrl_i, flush_i,
    output exmem_regwrite_i, memwb_regwrite_i, exmem_rd_i, memwb_rd_i,
    output exmem_data_i, memwb_data_i,
    input  alu_a_o, alu_b_o, alu_op_o, alu_pc_o, store_data_o,
    input  ex_rd_o, ex_ctrl_o, ex_valid_o, load_use_stall_o
  );

  modport slave (
    input  id_valid_i, id_pc_i, id_rd1_i, id_rd2_i, id_imm_i,
    input  id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i, id_use_rs2_i,
    input  id_aluop_i, id_alusrc_i, id_ctrl_i, flush_i,
    input  exmem_regwrite_i, memwb_regwrite_i, exmem_rd_i, memwb_rd_i,
    input  exmem_data_i, memwb_data_i,
    output alu_a_o, alu_b_o, alu_op_o, alu_pc_o, store_data_o,
    output ex_rd_o, ex_ctrl_o, ex_valid_o, load_use_stall_o
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with load-use bubble insertion, capture-side WB
// bypass and EX/MEM-over-MEM/WB operand forwarding into the ALU.
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input logic         clk,
  input logic         rstn,
  ex_operand_if.slave bus
);
  localparam logic [OPW-1:0] OP_NOP = '0;

  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] rs1v_p1;
  logic [XLEN-1:0] rs2v_p1;
  logic [XLEN-1:0] imm_p1;
  logic [4:0]      rs1_p1;
  logic [4:0]      rs2_p1;
  logic [4:0]      rd_p1;
  logic [OPW-1:0]  op_p1;
  logic            alusrc_p1;
  logic [7:0]      ctrl_p1;

  logic            stall;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;

  // Newest value of register rs; x0 never matches a writer.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] stored,
    input logic            mem_we,
    input logic [4:0]      mem_rd,
    input logic [XLEN-1:0] mem_data,
    input logic            wb_we,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) return mem_data;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) return wb_data;
    return stored;
  endfunction

  assign stall = vld_p1 && ctrl_p1[6] && (rd_p1 != 5'd0) && bus.id_valid_i &&
                 ((bus.id_use_rs1_i && (bus.id_rs1_i == rd_p1)) ||
                  (bus.id_use_rs2_i && (bus.id_rs2_i == rd_p1))) &&
                 !bus.flush_i;

  // ID -> EX boundary: reset, flush and load-use stall all load a zeroed bubble
  always_ff @(posedge clk) begin
    if (!rstn || bus.flush_i || stall) begin
      vld_p1    <= 1'b0;
      pc_p1     <= '0;
      rs1v_p1   <= '0;
      rs2v_p1   <= '0;
      imm_p1    <= '0;
      rs1_p1    <= '0;
      rs2_p1    <= '0;
      rd_p1     <= '0;
      op_p1     <= OP_NOP;
      alusrc_p1 <= 1'b0;
      ctrl_p1   <= '0;
    end else begin
      vld_p1    <= bus.id_valid_i;
      pc_p1     <= bus.id_pc_i;
      rs1v_p1   <= fwd_sel(bus.id_rs1_i, bus.id_rd1_i, 1'b0, 5'd0, '0,
                           bus.memwb_regwrite_i, bus.memwb_rd_i, bus.memwb_data_i);
      rs2v_p1   <= fwd_sel(bus.id_rs2_i, bus.id_rd2_i, 1'b0, 5'd0, '0,
                           bus.memwb_regwrite_i, bus.memwb_rd_i, bus.memwb_data_i);
      imm_p1    <= bus.id_imm_i;
      rs1_p1    <= bus.id_rs1_i;
      rs2_p1    <= bus.id_rs2_i;
      rd_p1     <= bus.id_rd_i;
      op_p1     <= bus.id_aluop_i;
      alusrc_p1 <= bus.id_alusrc_i;
      ctrl_p1   <= bus.id_ctrl_i;
    end
  end

  // EX: same-cycle forwarding onto the registered operands
  assign fwd1 = fwd_sel(rs1_p1, rs1v_p1,
                        bus.exmem_regwrite_i, bus.exmem_rd_i, bus.exmem_data_i,
                        bus.memwb_regwrite_i, bus.memwb_rd_i, bus.memwb_data_i);
  assign fwd2 = fwd_sel(rs2_p1, rs2v_p1,
                        bus.exmem_regwrite_i, bus.exmem_rd_i, bus.exmem_data_i,
                        bus.memwb_regwrite_i, bus.memwb_rd_i, bus.memwb_data_i);

  assign bus.alu_a_o          = fwd1;
  assign bus.alu_b_o          = alusrc_p1 ? imm_p1 : fwd2;
  assign bus.store_data_o     = fwd2;
  assign bus.alu_pc_o         = pc_p1;
  assign bus.alu_op_o         = op_p1;
  assign bus.ex_rd_o          = rd_p1;
  assign bus.ex_ctrl_o        = ctrl_p1;
  assign bus.ex_valid_o       = vld_p1;
  assign bus.load_use_stall_o = stall;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed hazard scenarios followed by random
// traffic compared against an instruction-level model of the EX slot.
module tb_ex_operand_stage;
  logic clk = 1'b0;
  logic rstn;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_operand_if #(.XLEN(32), .OPW(5)) bus ();

  ex_operand_stage #(.XLEN(32), .OPW(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  // Model of the instruction sitting in EX, with operand values as read in ID.
  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  op;
    logic        alusrc;
    logic [7:0]  ctrl;
  } ex_t;

  ex_t m;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Value register r will hold once every in-flight writer retires ahead of EX.
  function automatic logic [31:0] latest(input logic [4:0] r, input logic [31:0] stored);
    if (r == 5'd0) return stored;
    if (bus.exmem_regwrite_i && bus.exmem_rd_i == r) return bus.exmem_data_i;
    if (bus.memwb_regwrite_i && bus.memwb_rd_i == r) return bus.memwb_data_i;
    return stored;
  endfunction

  function automatic logic [31:0] id_read(input logic [4:0] r, input logic [31:0] rf);
    if (r != 5'd0 && bus.memwb_regwrite_i && bus.memwb_rd_i == r) return bus.memwb_data_i;
    return rf;
  endfunction

  function automatic logic model_stall();
    logic needs;
    needs = (bus.id_use_rs1_i && bus.id_rs1_i == m.rd) ||
            (bus.id_use_rs2_i && bus.id_rs2_i == m.rd);
    return m.vld && m.ctrl[6] && m.rd != 5'd0 && bus.id_valid_i && needs && !bus.flush_i;
  endfunction

  task automatic cmp_all();
    check_val("stall", 32'(bus.load_use_stall_o), 32'(model_stall()));
    check_val("valid", 32'(bus.ex_valid_o), 32'(m.vld));
    check_val("ctrl",  32'(bus.ex_ctrl_o), 32'(m.ctrl));
    check_val("op",    32'(bus.alu_op_o), 32'(m.op));
    check_val("rd",    32'(bus.ex_rd_o), 32'(m.rd));
    check_val("pc",    bus.alu_pc_o, m.pc);
    check_val("alu_a", bus.alu_a_o, latest(m.rs1, m.a));
    check_val("alu_b", bus.alu_b_o, m.alusrc ? m.imm : latest(m.rs2, m.b));
    check_val("store", bus.store_data_o, latest(m.rs2, m.b));
  endtask

  task automatic tick();
    ex_t nxt;
    logic st;
    st  = model_stall();
    @(posedge clk);
    nxt = '{vld: 1'b0, pc: '0, a: '0, b: '0, imm: '0, rs1: '0, rs2: '0,
            rd: '0, op: '0, alusrc: 1'b0, ctrl: '0};
    if (rstn && !bus.flush_i && !st) begin
      nxt.vld    = bus.id_valid_i;
      nxt.pc     = bus.id_pc_i;
      nxt.a      = id_read(bus.id_rs1_i, bus.id_rd1_i);
      nxt.b      = id_read(bus.id_rs2_i, bus.id_rd2_i);
      nxt.imm    = bus.id_imm_i;
      nxt.rs1    = bus.id_rs1_i;
      nxt.rs2    = bus.id_rs2_i;
      nxt.rd     = bus.id_rd_i;
      nxt.op     = bus.id_aluop_i;
      nxt.alusrc = bus.id_alusrc_i;
      nxt.ctrl   = bus.id_ctrl_i;
    end
    m = nxt;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.id_valid_i       = 1'b0;
    bus.id_pc_i          = '0;
    bus.id_rd1_i         = '0;
    bus.id_rd2_i         = '0;
    bus.id_imm_i         = '0;
    bus.id_rs1_i         = '0;
    bus.id_rs2_i         = '0;
    bus.id_rd_i          = '0;
    bus.id_use_rs1_i     = 1'b0;
    bus.id_use_rs2_i     = 1'b0;
    bus.id_aluop_i       = '0;
    bus.id_alusrc_i      = 1'b0;
    bus.id_ctrl_i        = '0;
    bus.flush_i          = 1'b0;
    bus.exmem_regwrite_i = 1'b0;
    bus.memwb_regwrite_i = 1'b0;
    bus.exmem_rd_i       = '0;
    bus.memwb_rd_i       = '0;
    bus.exmem_data_i     = '0;
    bus.memwb_data_i     = '0;
  endtask

  task automatic rand_inputs();
    bus.id_valid_i       = ($urandom_range(0, 5) != 0);
    bus.id_pc_i          = $urandom;
    bus.id_rd1_i         = $urandom;
    bus.id_rd2_i         = $urandom;
    bus.id_imm_i         = $urandom;
    bus.id_rs1_i         = 5'($urandom_range(0, 7));
    bus.id_rs2_i         = 5'($urandom_range(0, 7));
    bus.id_rd_i          = 5'($urandom_range(0, 7));
    bus.id_use_rs1_i     = 1'($urandom_range(0, 1));
    bus.id_use_rs2_i     = 1'($urandom_range(0, 1));
    bus.id_aluop_i       = 5'($urandom_range(0, 31));
    bus.id_alusrc_i      = 1'($urandom_range(0, 1));
    bus.id_ctrl_i        = 8'($urandom_range(0, 255));
    bus.flush_i          = ($urandom_range(0, 7) == 0);
    bus.exmem_regwrite_i = 1'($urandom_range(0, 1));
    bus.memwb_regwrite_i = 1'($urandom_range(0, 1));
    bus.exmem_rd_i       = 5'($urandom_range(0, 7));
    bus.memwb_rd_i       = 5'($urandom_range(0, 7));
    bus.exmem_data_i     = $urandom;
    bus.memwb_data_i     = $urandom;
  endtask

  task automatic load_x7_into_ex();
    idle();
    bus.id_valid_i = 1'b1;
    bus.id_rd_i    = 5'd7;
    bus.id_rs1_i   = 5'd2;
    bus.id_ctrl_i  = 8'hC0;
    tick();
    bus.id_valid_i   = 1'b1;
    bus.id_rs1_i     = 5'd7;
    bus.id_rs2_i     = 5'd1;
    bus.id_use_rs1_i = 1'b1;
    bus.id_use_rs2_i = 1'b1;
    bus.id_rd_i      = 5'd8;
    bus.id_rd1_i     = 32'h0000_0BAD;
    bus.id_rd2_i     = 32'h0000_0001;
    bus.id_ctrl_i    = 8'h80;
    bus.id_aluop_i   = 5'd1;
    bus.id_pc_i      = 32'h0000_0100;
  endtask

  initial begin
    m = '{vld: 1'b0, pc: '0, a: '0, b: '0, imm: '0, rs1: '0, rs2: '0,
          rd: '0, op: '0, alusrc: 1'b0, ctrl: '0};

    // Reset with random ID traffic
    rstn = 1'b0;
    rand_inputs();
    tick();
    rand_inputs();
    tick();
    bus.id_alusrc_i = 1'b0;
    #1;
    check_val("rst_valid", 32'(bus.ex_valid_o), 32'h0);
    check_val("rst_ctrl",  32'(bus.ex_ctrl_o), 32'h0);
    check_val("rst_op",    32'(bus.alu_op_o), 32'h0);
    check_val("rst_a",     bus.alu_a_o, 32'h0);
    check_val("rst_b",     bus.alu_b_o, 32'h0);
    check_val("rst_stall", 32'(bus.load_use_stall_o), 32'h0);
    rstn = 1'b1;

    // EX/MEM beats MEM/WB
    idle();
    bus.id_valid_i   = 1'b1;
    bus.id_rs1_i     = 5'd5;
    bus.id_rd1_i     = 32'h99;
    bus.id_use_rs1_i = 1'b1;
    bus.id_ctrl_i    = 8'h80;
    bus.id_aluop_i   = 5'd3;
    tick();
    idle();
    bus.exmem_regwrite_i = 1'b1;
    bus.exmem_rd_i       = 5'd5;
    bus.exmem_data_i     = 32'h11;
    bus.memwb_regwrite_i = 1'b1;
    bus.memwb_rd_i       = 5'd5;
    bus.memwb_data_i     = 32'h22;
    #1;
    check_val("fwd_exmem", bus.alu_a_o, 32'h11);
    cmp_all();
    bus.exmem_regwrite_i = 1'b0;
    #1;
    check_val("fwd_memwb", bus.alu_a_o, 32'h22);
    tick();

    // x0 is never forwarded
    idle();
    bus.id_valid_i   = 1'b1;
    bus.id_use_rs2_i = 1'b1;
    tick();
    idle();
    bus.exmem_regwrite_i = 1'b1;
    bus.exmem_rd_i       = 5'd0;
    bus.exmem_data_i     = 32'hDEAD;
    #1;
    check_val("x0_guard", bus.alu_b_o, 32'h0);
    tick();

    // Load-use: one bubble, then the held add picks up the load result
    load_x7_into_ex();
    #1;
    check_val("lu_stall", 32'(bus.load_use_stall_o), 32'h1);
    cmp_all();
    tick();
    bus.memwb_regwrite_i = 1'b1;
    bus.memwb_rd_i       = 5'd7;
    bus.memwb_data_i     = 32'h1234;
    #1;
    check_val("lu_bub_valid", 32'(bus.ex_valid_o), 32'h0);
    check_val("lu_bub_ctrl",  32'(bus.ex_ctrl_o), 32'h0);
    check_val("lu_bub_stall", 32'(bus.load_use_stall_o), 32'h0);
    tick();
    #1;
    check_val("lu_add_valid", 32'(bus.ex_valid_o), 32'h1);
    check_val("lu_add_rd",    32'(bus.ex_rd_o), 32'h8);
    check_val("lu_add_a",     bus.alu_a_o, 32'h1234);
    cmp_all();
    tick();

    // Flush overrides the stall and discards ID
    load_x7_into_ex();
    bus.flush_i = 1'b1;
    #1;
    check_val("fl_stall", 32'(bus.load_use_stall_o), 32'h0);
    tick();
    idle();
    #1;
    check_val("fl_valid", 32'(bus.ex_valid_o), 32'h0);
    check_val("fl_ctrl",  32'(bus.ex_ctrl_o), 32'h0);
    check_val("fl_rd",    32'(bus.ex_rd_o), 32'h0);
    check_val("fl_pc",    bus.alu_pc_o, 32'h0);

    // Same-cycle WB write seen at capture
    idle();
    bus.id_valid_i       = 1'b1;
    bus.id_rs2_i         = 5'd3;
    bus.id_rd2_i         = 32'hAAAA;
    bus.id_use_rs2_i     = 1'b1;
    bus.memwb_regwrite_i = 1'b1;
    bus.memwb_rd_i       = 5'd3;
    bus.memwb_data_i     = 32'h5555;
    tick();
    idle();
    #1;
    check_val("wb_byp_b",     bus.alu_b_o, 32'h5555);
    check_val("wb_byp_store", bus.store_data_o, 32'h5555);
    cmp_all();
    tick();

    // Random traffic, including mid-stream resets and flushes
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      rstn = ($urandom_range(0, 39) != 0);
      #1;
      cmp_all();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-select logic feeding the ALU in the pipelined RISC-V core.
- Captures decoded instruction state from ID each cycle.
- Resolves EX/MEM and MEM/WB forwarding and presents the final A, B, ALUOp and PC to the ALU.
- Detects load-use hazards and inserts bubbles on stall or branch flush.

Parameters:
XLEN, 32, datapath width
OPW, 5, ALUOp width; matches ALU op encoding

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, synchronous, active-low
id_valid_i  in  1  ID holds a real instruction
id_pc_i  in  XLEN  PC of ID instruction
id_rd1_i, id_rd2_i  in  XLEN  register-file read data
id_imm_i  in  XLEN  sign-extended immediate
id_rs1_i, id_rs2_i, id_rd_i  in  5  register indices
id_use_rs1_i, id_use_rs2_i  in  1  instruction actually reads rs1/rs2
id_aluop_i  in  OPW  ALU operation
id_alusrc_i  in  1  1: B=imm, 0: B=rs2
id_ctrl_i  in  8  {regwrite, memread, memwrite, wdsel[1:0], branch, jal, jalr}
flush_i  in  1  branch/jump taken in EX; kill ID instruction
exmem_regwrite_i, memwb_regwrite_i  in  1  later-stage write enables
exmem_rd_i, memwb_rd_i  in  5  later-stage destinations
exmem_data_i, memwb_data_i  in  XLEN  later-stage result values
alu_a_o, alu_b_o  out  XLEN  ALU operands
alu_op_o  out  OPW  ALU operation
alu_pc_o  out  XLEN  PC to ALU (auipc/branch target)
store_data_o  out  XLEN  forwarded rs2 for stores
ex_rd_o  out  5  EX destination
ex_ctrl_o  out  8  EX control bundle; all-zero when bubble
ex_valid_o  out  1  EX holds a real instruction
load_use_stall_o  out  1  hold PC and IF/ID this cycle

Behaviour:
- All state updates on posedge clk. rstn=0 at an edge clears every register:
  - valid=0, ctrl=0, rd/rs=0, pc/data/imm=0.
  - alu_op = nop encoding (0).
  - Outputs therefore reset to 0 / nop one edge later.
  - Reset mid-stream discards the captured instruction; no partial state survives.
- load_use_stall_o (combinational):
  - Asserted when ex_valid && ex_memread && ex_rd!=0 && id_valid && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)) && !flush_i.
- Capture priority at each edge with rstn=1:
  - flush_i: bubble.
  - else load_use_stall_o: bubble.
  - else: capture ID fields.
  - Bubble means valid=0, ctrl=0, alu_op=nop, rd=0. Other fields are don't-care but are driven 0.
- Capture-side WB bypass: when capturing, if memwb_regwrite && memwb_rd!=0 && memwb_rd==id_rsN, the stored rsN value is memwb_data_i instead of id_rdN_i. Covers same-cycle register-file write/read.
- EX forwarding (combinational on registered state), per operand N in {1,2}:
  - if exmem_regwrite && exmem_rd!=0 && exmem_rd==ex_rsN: exmem_data_i.
  - else if memwb_regwrite && memwb_rd!=0 && memwb_rd==ex_rsN: memwb_data_i.
  - else: stored value.
  - EX/MEM always wins over MEM/WB. x0 is never forwarded.
- alu_a_o = fwd_rs1.
- alu_b_o = alusrc ? imm : fwd_rs2.
- store_data_o = fwd_rs2, independent of alusrc.
- alu_pc_o = registered pc.
- alu_op_o, ex_rd_o, ex_ctrl_o, ex_valid_o come directly from registers.
- Latency: one cycle from ID inputs to EX outputs. Forwarding adds no cycle.
- A stalled load-use pair yields exactly one bubble. The held ID instruction is captured on the next edge, with its operand forwarded from MEM/WB.
- flush_i and stall together: flush wins and the stall output is low.

Test Plan:
- Reset: rstn=0 for 2 edges with random ID inputs -> ex_valid_o=0, ex_ctrl_o=0, alu_op_o=0, alu_a_o=alu_b_o=0; load_use_stall_o=0.
- Forward EX/MEM over MEM/WB: EX has rs1=5; exmem rd=5 data=0x11; memwb rd=5 data=0x22 -> alu_a_o=0x11. Clear exmem_regwrite -> 0x22.
- x0 guard: exmem_regwrite=1, rd=0, data=0xDEAD, EX rs2=0, stored 0, alusrc=0 -> alu_b_o=0.
- Load-use: EX holds lw x7 (memread=1); ID add x8,x7,x1 -> load_use_stall_o=1. Next edge: ex_valid_o=0, ex_ctrl_o=0. Following edge: add captured and alu_a_o = memwb_data_i (0x1234).
- Flush priority: same load-use setup with flush_i=1 -> load_use_stall_o=0. Next edge: bubble; nothing from ID captured.
- WB capture bypass: id_rs2=3, id_rd2_i=0xAAAA, memwb_regwrite=1, rd=3, data=0x5555, alusrc=0 -> after edge, with no later-stage match, alu_b_o=0x5555 and store_data_o=0x5555.
